// File: rtl/fetch_pkg.sv
// fetch_pkg: shared sizes, NOP encoding and the FIFO entry layout for the fetch stage.
package fetch_pkg;
    localparam int DEPTH = 4;
    localparam int XLEN = 32;
    localparam int PC_W = 10;
    localparam int IADDR_W = 8;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;
    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [XLEN-1:0] instr;
    } entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: in-order circular queue with clear; head shows the oldest entry.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd, wr;
    logic do_push, do_pop;

    function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign do_pop = pop && (count != '0);
    assign do_push = push && (count != FULL);
    assign head = mem[rd];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd <= '0;
            wr <= '0;
            count <= '0;
        end else if (clear) begin
            rd <= '0;
            wr <= '0;
            count <= '0;
        end else begin
            if (do_push) wr <= nxt(wr);
            if (do_pop) rd <= nxt(rd);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr] <= din;
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: issues imem reads under FIFO credit, queues returns with their pc,
// and hands them to decode with a valid/ready handshake; flush squashes everything.
module fetch_unit
    import fetch_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [PC_W-1:0]    pc_in,
    input  logic               flush,
    output logic               stall_out,
    output logic               imem_en,
    output logic [IADDR_W-1:0] imem_addr,
    input  logic [XLEN-1:0]    imem_rdata,
    output logic [XLEN-1:0]    instr_out,
    output logic [PC_W-1:0]    instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic               misalign_err
);
    logic [CNT_W-1:0] count, credit;
    logic inflight, has_credit, misalign, squash, push, pop;
    logic [PC_W-1:0] inflight_pc;
    entry_t head, ret;

    // An in-flight read is counted as occupied so its return always has a slot.
    assign credit = count + CNT_W'(inflight);
    assign has_credit = credit < FULL;
    assign stall_out = !has_credit;
    assign misalign = pc_in[1:0] != 2'b00;
    assign imem_en = !reset && !flush && !misalign && has_credit;
    assign imem_addr = pc_in[PC_W-1:2];
    assign squash = flush && inflight;
    assign push = inflight && !squash;
    assign instr_valid = count != '0;
    assign pop = instr_valid && instr_ready;
    assign instr_out = instr_valid ? head.instr : NOP;
    assign instr_pc = instr_valid ? head.pc : '0;
    assign ret = '{pc: inflight_pc, instr: imem_rdata};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inflight <= 1'b0;
            inflight_pc <= '0;
            misalign_err <= 1'b0;
        end else begin
            inflight <= imem_en;
            if (imem_en) inflight_pc <= pc_in;
            if (!flush && has_credit && misalign) misalign_err <= 1'b1;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH), .WIDTH($bits(entry_t)), .CNT_W(CNT_W)) u_fifo (
        .clk(clk),
        .reset(reset),
        .push(push),
        .pop(pop),
        .clear(flush),
        .din(ret),
        .head(head),
        .count(count)
    );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector table for streaming/backpressure plus hand sequences
// for flush, misalignment and asynchronous reset.
module tb_fetch_unit;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [9:0] pc_in = '0;
    logic flush = 1'b0;
    logic stall_out, imem_en, instr_valid, instr_ready, misalign_err;
    logic [7:0] imem_addr;
    logic [31:0] imem_rdata, instr_out;
    logic [9:0] instr_pc;
    int tests = 0;
    int fails = 0;

    typedef struct {
        logic rst;
        logic ready;
        logic valid;
        logic [31:0] instr;
        logic [9:0] pc;
        logic en;
        logic stall;
    } vec_t;
    vec_t vecs[19];

    fetch_unit dut (
        .clk(clk), .reset(reset), .pc_in(pc_in), .flush(flush),
        .stall_out(stall_out), .imem_en(imem_en), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .instr_out(instr_out), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory: word at address a holds 0xA0 + a.
    always @(posedge clk) imem_rdata <= imem_en ? 32'hA0 + {24'h0, imem_addr} : 32'hDEAD_BEEF;

    function automatic vec_t mk(logic rst, logic rdy, logic v, logic [31:0] ins,
                                logic [9:0] pc, logic en, logic st);
        vec_t r;
        r.rst = rst; r.ready = rdy; r.valid = v; r.instr = ins; r.pc = pc; r.en = en; r.stall = st;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one edge; the pc block model steps pc_in after every issue.
    task automatic tick();
        logic en_q;
        en_q = imem_en;
        @(posedge clk);
        #1;
        if (en_q) pc_in = pc_in + 10'd4;
    endtask

    task automatic do_reset();
        #1;
        reset = 1'b1;
        flush = 1'b0;
        pc_in = '0;
        instr_ready = 1'b0;
        #1;
        chk("rst valid", instr_valid, 0);
        chk("rst instr", instr_out, NOP);
        chk("rst pc", instr_pc, 0);
        chk("rst en", imem_en, 0);
        chk("rst stall", stall_out, 0);
        chk("rst err", misalign_err, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        instr_ready = 1'b0;
        vecs[0]  = mk(1, 1, 0, NOP,          0, 1, 0);
        vecs[1]  = mk(0, 1, 0, NOP,          0, 1, 0);
        vecs[2]  = mk(0, 1, 1, 32'hA0,       0, 1, 0);
        vecs[3]  = mk(0, 1, 1, 32'hA1,       4, 1, 0);
        vecs[4]  = mk(0, 1, 1, 32'hA2,       8, 1, 0);
        vecs[5]  = mk(0, 1, 1, 32'hA3,      12, 1, 0);
        vecs[6]  = mk(1, 0, 0, NOP,          0, 1, 0);
        vecs[7]  = mk(0, 0, 0, NOP,          0, 1, 0);
        vecs[8]  = mk(0, 0, 1, 32'hA0,       0, 1, 0);
        vecs[9]  = mk(0, 0, 1, 32'hA0,       0, 1, 0);
        vecs[10] = mk(0, 0, 1, 32'hA0,       0, 0, 1);
        vecs[11] = mk(0, 0, 1, 32'hA0,       0, 0, 1);
        vecs[12] = mk(0, 0, 1, 32'hA0,       0, 0, 1);
        vecs[13] = mk(0, 1, 1, 32'hA0,       0, 0, 1);
        vecs[14] = mk(0, 1, 1, 32'hA1,       4, 1, 0);
        vecs[15] = mk(0, 1, 1, 32'hA2,       8, 1, 0);
        vecs[16] = mk(0, 1, 1, 32'hA3,      12, 1, 0);
        vecs[17] = mk(0, 1, 1, 32'hA4,      16, 1, 0);
        vecs[18] = mk(0, 1, 1, 32'hA5,      20, 1, 0);

        for (int i = 0; i < 19; i++) begin
            if (vecs[i].rst) do_reset();
            instr_ready = vecs[i].ready;
            @(negedge clk);
            chk($sformatf("v%0d valid", i), instr_valid, vecs[i].valid);
            chk($sformatf("v%0d instr", i), instr_out, vecs[i].instr);
            chk($sformatf("v%0d pc", i), instr_pc, vecs[i].pc);
            chk($sformatf("v%0d en", i), imem_en, vecs[i].en);
            chk($sformatf("v%0d stall", i), stall_out, vecs[i].stall);
            tick();
        end

        // Flush with three queued and one in flight.
        do_reset();
        for (int i = 0; i < 4; i++) tick();
        flush = 1'b1;
        pc_in = 10'd196;
        @(negedge clk);
        chk("flush en", imem_en, 0);
        tick();
        flush = 1'b0;
        instr_ready = 1'b1;
        @(negedge clk);
        chk("flush valid0", instr_valid, 0);
        chk("flush instr0", instr_out, NOP);
        chk("flush en1", imem_en, 1);
        tick();
        @(negedge clk);
        chk("flush valid1", instr_valid, 0);
        tick();
        @(negedge clk);
        chk("flush first valid", instr_valid, 1);
        chk("flush first pc", instr_pc, 196);
        chk("flush first instr", instr_out, 32'hD1);
        tick();
        @(negedge clk);
        chk("flush second pc", instr_pc, 200);
        chk("flush second instr", instr_out, 32'hD2);

        // Misaligned pc is never issued and the error sticks until reset.
        do_reset();
        pc_in = 10'd802;
        @(negedge clk);
        chk("mis en", imem_en, 0);
        chk("mis err0", misalign_err, 0);
        tick();
        @(negedge clk);
        chk("mis err1", misalign_err, 1);
        tick();
        tick();
        pc_in = 10'd0;
        @(negedge clk);
        chk("mis err sticky", misalign_err, 1);
        chk("mis en aligned", imem_en, 1);
        chk("mis valid", instr_valid, 0);

        // Asynchronous reset between edges with two entries queued.
        do_reset();
        for (int i = 0; i < 3; i++) tick();
        @(negedge clk);
        chk("ar valid before", instr_valid, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("ar valid", instr_valid, 0);
        chk("ar instr", instr_out, NOP);
        chk("ar pc", instr_pc, 0);
        chk("ar en", imem_en, 0);
        chk("ar stall", stall_out, 0);
        #1;
        reset = 1'b0;
        pc_in = 10'd64;
        instr_ready = 1'b1;
        tick();
        @(negedge clk);
        chk("ar post valid", instr_valid, 0);
        tick();
        @(negedge clk);
        chk("ar post first valid", instr_valid, 1);
        chk("ar post first pc", instr_pc, 64);
        chk("ar post first instr", instr_out, 32'hB0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
